mem_bus_arbiter: RTL

Shares the single SRAM-like memory bus between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the five-stage CPU. It holds at most one transaction outstanding and gives priority to data. It discards instruction responses cancelled by a pipeline flush. It produces per-requester stall requests that the pipeline control block folds into the stall bus.

---
 rtl/mem_bus_arbiter_pkg.sv | 27 ++
 rtl/mem_arb_perf.sv | 39 +++
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared encodings for the IF/MEM memory-bus arbiter:
//   arb_state_t : arbiter FSM states (ARB_IDLE / ARB_ADDR / ARB_DATA, 2 bits)
//   owner_t     : requester that owns the outstanding transaction
//   size_t      : bus access size encodings (byte / half / word)
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_DATA = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_t;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } size_t;

endpackage

// File: rtl/mem_arb_perf.sv
// -----------------------------------------------------------------------------
// mem_arb_perf
// Performance counters for mem_bus_arbiter. Only built when MEM_ARB_PERF_EN
// is defined; otherwise this file contributes nothing.
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   inst_ok       : delivered instruction completion pulse
//   data_ok       : data completion pulse
//   wait_cyc      : a requester is stalled this cycle
//   inst_cnt      : number of delivered fetches (wraps at 2^32)
//   data_cnt      : number of completed data accesses (wraps at 2^32)
//   wait_cnt      : number of stalled cycles (wraps at 2^32)
// -----------------------------------------------------------------------------
`ifdef MEM_ARB_PERF_EN
module mem_arb_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_ok,
   input  logic        data_ok,
   input  logic        wait_cyc,
   output logic [31:0] inst_cnt,
   output logic [31:0] data_cnt,
   output logic [31:0] wait_cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         inst_cnt <= '0;
         data_cnt <= '0;
         wait_cnt <= '0;
      end else begin
         if (inst_ok)  inst_cnt <= inst_cnt + 32'd1;
         if (data_ok)  data_cnt <= data_cnt + 32'd1;
         if (wait_cyc) wait_cnt <= wait_cnt + 32'd1;
      end
   end

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one SRAM-like memory bus between the IF-stage fetch requester and the
// MEM-stage data requester. One transaction outstanding at a time, data has
// priority, fetches cancelled by a pipeline flush complete on the bus but their
// response is dropped.
// Optional feature: define MEM_ARB_PERF_EN to build the performance counters
// (mem_arb_perf); otherwise perf_* outputs are tied to zero.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   flush                          : pipeline flush, cancels fetches only
//   inst_req/inst_addr             : fetch request (level) and address
//   inst_data_ok/inst_rdata        : fetch completion pulse and data
//   data_req/wr/size/addr/wdata    : data request (level) and fields
//   data_data_ok/data_rdata        : data completion pulse and load data
//   bus_req/wr/size/addr/wdata     : downstream request, held until bus_addr_ok
//   bus_addr_ok/bus_data_ok/rdata  : downstream handshake and read data
//   stallreq_for_inst/_data        : requester waiting on its completion
//   perf_inst/data/wait_cnt        : performance counters
// -----------------------------------------------------------------------------
module mem_bus_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata,
   output logic        stallreq_for_inst,
   output logic        stallreq_for_data,
   output logic [31:0] perf_inst_cnt,
   output logic [31:0] perf_data_cnt,
   output logic [31:0] perf_wait_cnt
);

   import mem_bus_arbiter_pkg::*;

   arb_state_t state;
   owner_t     owner;
   logic       cancel;
   logic       resp;

   // Single FSM block. bus_req is a register (set on grant, cleared on
   // bus_addr_ok) so the downstream sees a glitch-free, stable request.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB_IDLE;
         owner     <= OWN_INST;
         cancel    <= 1'b0;
         bus_req   <= 1'b0;
         bus_wr    <= 1'b0;
         bus_size  <= 2'b00;
         bus_addr  <= '0;
         bus_wdata <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (data_req) begin
                  owner     <= OWN_DATA;
                  bus_req   <= 1'b1;
                  bus_wr    <= data_wr;
                  bus_size  <= data_size;
                  bus_addr  <= data_addr;
                  bus_wdata <= data_wdata;
                  state     <= ARB_ADDR;
               end else if (inst_req && !flush) begin
                  owner     <= OWN_INST;
                  bus_req   <= 1'b1;
                  bus_wr    <= 1'b0;
                  bus_size  <= SIZE_W;
                  bus_addr  <= inst_addr;
                  bus_wdata <= '0;
                  state     <= ARB_ADDR;
               end
            end
            ARB_ADDR: begin
               // A request cannot be retracted; a flush only marks the fetch
               // so its response is dropped later.
               if (flush && owner == OWN_INST) cancel <= 1'b1;
               if (bus_addr_ok) begin
                  bus_req <= 1'b0;
                  state   <= ARB_DATA;
               end
            end
            ARB_DATA: begin
               if (bus_data_ok) begin
                  cancel <= 1'b0;
                  state  <= ARB_IDLE;
               end else if (flush && owner == OWN_INST) begin
                  cancel <= 1'b1;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // Completion is combinational on bus_data_ok so the pipeline advances in
   // the same cycle. bus_data_ok outside DATA is a protocol error and ignored;
   // a reset cycle never reports completion.
   assign resp         = (state == ARB_DATA) && bus_data_ok && !rst;
   assign inst_data_ok = resp && (owner == OWN_INST) && !cancel;
   assign data_data_ok = resp && (owner == OWN_DATA);
   assign inst_rdata   = bus_rdata;
   assign data_rdata   = bus_rdata;

   assign stallreq_for_inst = inst_req && !inst_data_ok;
   assign stallreq_for_data = data_req && !data_data_ok;

`ifdef MEM_ARB_PERF_EN
   mem_arb_perf u_perf (
      .clk      (clk),
      .rst      (rst),
      .inst_ok  (inst_data_ok),
      .data_ok  (data_data_ok),
      .wait_cyc (stallreq_for_inst || stallreq_for_data),
      .inst_cnt (perf_inst_cnt),
      .data_cnt (perf_data_cnt),
      .wait_cnt (perf_wait_cnt)
   );
`else
   assign perf_inst_cnt = '0;
   assign perf_data_cnt = '0;
   assign perf_wait_cnt = '0;
`endif

endmodule
